mem8x8_ctrl: RTL and testbench

- Synchronous access controller for the 8x8 bitcell memory array (8 rows x 8 bits; per-bit inp/rw/sel cells).
- Arbitrates two requesters (A, B) with valid/ready handshakes, round-robin.
- Sequences the array's level-sensitive rw/sel lines so that rw and data change only while every row select is low. This prevents spurious latching and read glitches.
- Returns a one-cycle response pulse per transaction.

---
 rtl/mem8x8_ctrl_pkg.sv | 19 +
 rtl/mem8x8_ctrl_rr_arb2.sv | 17 +
 rtl/mem8x8_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem8x8_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem8x8_ctrl_pkg.sv
// Shared definitions for the 8x8 bitcell array controller: FSM states,
// default geometry and requester identifiers.
package mem8x8_ctrl_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    RELEASE = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/mem8x8_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins; under contention
// the requester that was not granted last time wins.
module rr_arb2
  import mem8x8_ctrl_pkg::*;
(
  input  logic valid_a,
  input  logic valid_b,
  input  logic enable,
  input  logic last_grant,
  output logic grant_a,
  output logic grant_b
);

  assign grant_a = enable && valid_a && (!valid_b || (last_grant == REQ_B));
  assign grant_b = enable && valid_b && (!valid_a || (last_grant == REQ_A));

endmodule

// File: rtl/mem8x8_ctrl.sv
// Access controller for the 8x8 bitcell array. Sequences rw/din/sel so that
// rw and data only ever change while every row select is low.
module mem8x8_ctrl
  import mem8x8_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int READ_WAIT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic                       a_we,
  input  logic [ADDR_W-1:0]          a_addr,
  input  logic [DATA_W-1:0]          a_wdata,
  output logic                       a_rsp_valid,
  output logic [DATA_W-1:0]          a_rdata,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic                       b_we,
  input  logic [ADDR_W-1:0]          b_addr,
  input  logic [DATA_W-1:0]          b_wdata,
  output logic                       b_rsp_valid,
  output logic [DATA_W-1:0]          b_rdata,
  output logic                       mem_rw,
  output logic [(1 << ADDR_W)-1:0]   mem_sel,
  output logic [DATA_W-1:0]          mem_din,
  input  logic [DATA_W-1:0]          mem_dout,
  output logic                       busy
);

  localparam int ROWS  = 1 << ADDR_W;
  localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  state_t              state;
  logic                lat_we;
  logic                lat_id;
  logic                last_grant;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   cap_data;
  logic [CNT_W-1:0]    cnt;
  logic                grant_a;
  logic                grant_b;
  logic                strobe_done;

  rr_arb2 u_arb (
    .valid_a    (a_valid),
    .valid_b    (b_valid),
    .enable     (state == IDLE),
    .last_grant (last_grant),
    .grant_a    (grant_a),
    .grant_b    (grant_b)
  );

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign busy        = (state != IDLE);
  assign strobe_done = lat_we || (cnt == CNT_W'(READ_WAIT - 1));

  // rw/din are loaded at acceptance and held through RELEASE; sel is only
  // raised one cycle after rw/din settle and dropped one cycle before they move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_id      <= REQ_A;
      lat_addr    <= '0;
      last_grant  <= REQ_B;
      cap_data    <= '0;
      cnt         <= '0;
      mem_rw      <= 1'b0;
      mem_sel     <= '0;
      mem_din     <= '0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          mem_rw  <= 1'b0;
          mem_din <= '0;
          mem_sel <= '0;
          if (grant_a || grant_b) begin
            lat_id     <= grant_b ? REQ_B : REQ_A;
            last_grant <= grant_b ? REQ_B : REQ_A;
            lat_we     <= grant_b ? b_we : a_we;
            lat_addr   <= grant_b ? b_addr : a_addr;
            mem_rw     <= grant_b ? b_we : a_we;
            if (grant_b) begin
              mem_din <= b_we ? b_wdata : '0;
            end else begin
              mem_din <= a_we ? a_wdata : '0;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          mem_sel <= ROWS'(1) << lat_addr;
          cnt     <= '0;
          state   <= STROBE;
        end
        STROBE: begin
          if (strobe_done) begin
            mem_sel <= '0;
            if (!lat_we) begin
              cap_data <= mem_dout;
            end
            state <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (lat_id == REQ_A) begin
            a_rsp_valid <= 1'b1;
            if (!lat_we) begin
              a_rdata <= cap_data;
            end
          end else begin
            b_rsp_valid <= 1'b1;
            if (!lat_we) begin
              b_rdata <= cap_data;
            end
          end
          state <= RESP;
        end
        RESP: begin
          mem_rw  <= 1'b0;
          mem_din <= '0;
          state   <= IDLE;
        end
        default: begin
          mem_sel <= '0;
          mem_rw  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// Self-checking bench for mem8x8_ctrl: directed and random transactions
// against a cycle-level model of the handshake, timing and array contents.
module tb_mem8x8_ctrl;

  localparam int RW = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_we, a_ready, a_rsp_valid;
  logic [2:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       b_valid, b_we, b_ready, b_rsp_valid;
  logic [2:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic       mem_rw, busy;
  logic [7:0] mem_sel, mem_din, mem_dout;

  logic       c_valid, c_we, c_ready, c_rsp_valid, c_mem_rw, c_busy;
  logic [2:0] c_addr;
  logic [7:0] c_wdata, c_rdata, c_mem_sel, c_mem_din, c_mem_dout;
  logic       d_ready, d_rsp_valid;
  logic [7:0] d_rdata;

  logic [7:0] arr    [8] = '{default: 8'h00};
  logic [7:0] arr3   [8] = '{default: 8'h00};
  logic [7:0] shadow [8] = '{default: 8'h00};

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic       last_b;
  bit         inflight;
  int         acc_cyc;
  logic       in_id, in_we;
  logic [2:0] in_addr;
  logic [7:0] in_wd, in_rval, exp_a_rdata, exp_b_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem8x8_ctrl #(.ADDR_W(3), .DATA_W(8), .READ_WAIT(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata),
    .mem_rw(mem_rw), .mem_sel(mem_sel), .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
  );

  mem8x8_ctrl #(.ADDR_W(3), .DATA_W(8), .READ_WAIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(c_valid), .a_ready(c_ready), .a_we(c_we), .a_addr(c_addr), .a_wdata(c_wdata),
    .a_rsp_valid(c_rsp_valid), .a_rdata(c_rdata),
    .b_valid(1'b0), .b_ready(d_ready), .b_we(1'b0), .b_addr(3'd0), .b_wdata(8'h00),
    .b_rsp_valid(d_rsp_valid), .b_rdata(d_rdata),
    .mem_rw(c_mem_rw), .mem_sel(c_mem_sel), .mem_din(c_mem_din), .mem_dout(c_mem_dout),
    .busy(c_busy)
  );

  // Bitcell array models: a selected row latches din while rw is high.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_sel[i] && mem_rw) arr[i] <= mem_din;
      if (c_mem_sel[i] && c_mem_rw) arr3[i] <= c_mem_din;
    end
  end

  always_comb begin
    mem_dout   = 8'h00;
    c_mem_dout = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (mem_sel[i] && !mem_rw) mem_dout = arr[i];
      if (c_mem_sel[i] && !c_mem_rw) c_mem_dout = arr3[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Array-side invariants, sampled on the falling edge.
  logic       prev_ok = 1'b0;
  logic       prev_sel_nz = 1'b0;
  logic       prev_rw = 1'b0;
  logic [7:0] prev_din = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("sel_onehot0", 32'($onehot0(mem_sel)), 1);
      checkOutput("ready_excl", a_ready & b_ready, 0);
      checkOutput("rsp_excl", a_rsp_valid & b_rsp_valid, 0);
      if (prev_ok && (prev_sel_nz || mem_sel != 8'h00)) begin
        checkOutput("rw_stable", mem_rw, prev_rw);
        checkOutput("din_stable", mem_din, prev_din);
      end
    end
    prev_ok     <= rst_n;
    prev_sel_nz <= (mem_sel != 8'h00);
    prev_rw     <= mem_rw;
    prev_din    <= mem_din;
  end

  // Presents up to two requests and follows them to completion, checking the
  // bus and responses every cycle against the expected transaction timeline.
  task automatic applyStimulus(input bit va, input logic wa, input logic [2:0] aa, input logic [7:0] da,
                               input bit vb, input logic wb, input logic [2:0] ab, input logic [7:0] db);
    bit pa, pb, ga, gb, fin;
    int k, s, budget;
    @(negedge clk); #1;
    a_valid = va; a_we = wa; a_addr = aa; a_wdata = da;
    b_valid = vb; b_we = wb; b_addr = ab; b_wdata = db;
    pa = va; pb = vb;
    #1;
    budget = 0;
    while ((pa || pb || inflight) && budget < 40) begin
      budget++;
      fin = 0; ga = 0; gb = 0;
      if (inflight) begin
        k = cyc - acc_cyc;
        s = in_we ? 1 : RW;
        checkOutput("busy", busy, 1);
        checkOutput("mem_sel", mem_sel, (k >= 2 && k <= 1 + s) ? 8'(1 << in_addr) : 8'h00);
        if (k <= 2 + s) begin
          checkOutput("mem_rw", mem_rw, in_we);
          checkOutput("mem_din", mem_din, in_we ? in_wd : 8'h00);
        end
        if (k == 3 + s) begin
          fin = 1;
          if (!in_we && in_id) exp_b_rdata = in_rval;
          if (!in_we && !in_id) exp_a_rdata = in_rval;
        end
        checkOutput("a_rsp_valid", a_rsp_valid, fin && !in_id);
        checkOutput("b_rsp_valid", b_rsp_valid, fin && in_id);
      end else begin
        checkOutput("busy_idle", busy, 0);
        checkOutput("mem_sel_idle", mem_sel, 8'h00);
        checkOutput("mem_rw_idle", mem_rw, 0);
        checkOutput("a_rsp_idle", a_rsp_valid, 0);
        checkOutput("b_rsp_idle", b_rsp_valid, 0);
        ga = pa && (!pb || last_b);
        gb = pb && (!pa || !last_b);
      end
      checkOutput("a_ready", a_ready, ga);
      checkOutput("b_ready", b_ready, gb);
      checkOutput("a_rdata", a_rdata, exp_a_rdata);
      checkOutput("b_rdata", b_rdata, exp_b_rdata);
      if (ga || gb) begin
        inflight = 1;
        acc_cyc  = cyc;
        in_id    = gb;
        in_we    = gb ? wb : wa;
        in_addr  = gb ? ab : aa;
        in_wd    = gb ? db : da;
        last_b   = gb;
        if (in_we) shadow[in_addr] = in_wd;
        else in_rval = shadow[in_addr];
      end
      if (fin) inflight = 0;
      @(negedge clk); #1;
      if (ga) begin
        pa = 0; a_valid = 0;
        a_we = 1'($urandom_range(0, 1)); a_addr = 3'($urandom_range(0, 7)); a_wdata = 8'($urandom_range(0, 255));
      end
      if (gb) begin
        pb = 0; b_valid = 0;
        b_we = 1'($urandom_range(0, 1)); b_addr = 3'($urandom_range(0, 7)); b_wdata = 8'($urandom_range(0, 255));
      end
      #1;
    end
    checkOutput("txn_complete", 32'(pa || pb || inflight), 0);
  endtask

  // Single transaction on the READ_WAIT=3 instance.
  task automatic runLongRead(input logic we, input logic [2:0] addr, input logic [7:0] data);
    int s;
    bit got;
    s = we ? 1 : 3;
    @(negedge clk); #1;
    c_valid = 1'b1; c_we = we; c_addr = addr; c_wdata = data;
    #1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (c_ready) got = 1;
      else begin
        @(negedge clk); #2;
      end
    end
    checkOutput("c_accept", got, 1);
    @(negedge clk); #1;
    c_valid = 1'b0;
    for (int k = 1; k <= 3 + s; k++) begin
      checkOutput("c_mem_sel", c_mem_sel, (k >= 2 && k <= 1 + s) ? 8'(1 << addr) : 8'h00);
      checkOutput("c_rsp_valid", c_rsp_valid, k == 3 + s);
      if (k == 3 + s && !we) checkOutput("c_rdata", c_rdata, data);
      @(negedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    c_valid = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    last_b = 1'b1; inflight = 0; acc_cyc = 0;
    in_id = 0; in_we = 0; in_addr = 0; in_wd = 0; in_rval = 0;
    exp_a_rdata = 8'h00; exp_b_rdata = 8'h00;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_mem_sel", mem_sel, 8'h00);
    checkOutput("rst_mem_rw", mem_rw, 0);
    checkOutput("rst_mem_din", mem_din, 8'h00);
    checkOutput("rst_a_rsp", a_rsp_valid, 0);
    checkOutput("rst_b_rsp", b_rsp_valid, 0);
    checkOutput("rst_a_rdata", a_rdata, 8'h00);
    checkOutput("rst_b_rdata", b_rdata, 8'h00);
    checkOutput("rst_busy", busy, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    $display("[TB] directed: write, read-back, contention");
    applyStimulus(1, 1, 3'd3, 8'hA5, 0, 0, 3'd0, 8'h00);
    applyStimulus(1, 0, 3'd3, 8'h00, 0, 0, 3'd0, 8'h00);
    applyStimulus(1, 1, 3'd1, 8'h11, 1, 1, 3'd2, 8'h22);
    applyStimulus(1, 0, 3'd1, 8'h00, 1, 0, 3'd2, 8'h00);
    applyStimulus(0, 0, 3'd0, 8'h00, 1, 0, 3'd3, 8'h00);

    $display("[TB] reset during write strobe");
    @(negedge clk); #1;
    a_valid = 1; a_we = 1; a_addr = 3'd5; a_wdata = 8'h3C;
    #1;
    checkOutput("abort_ready", a_ready, 1);
    @(negedge clk); #1;
    a_valid = 0;
    @(posedge clk); #1;
    checkOutput("abort_sel_before", mem_sel, 8'h20);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_sel", mem_sel, 8'h00);
    checkOutput("abort_rw", mem_rw, 0);
    checkOutput("abort_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checkOutput("abort_a_rsp", a_rsp_valid, 0);
      checkOutput("abort_b_rsp", b_rsp_valid, 0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    last_b = 1'b1; inflight = 0;
    exp_a_rdata = 8'h00; exp_b_rdata = 8'h00;
    applyStimulus(1, 0, 3'd1, 8'h00, 1, 0, 3'd2, 8'h00);

    $display("[TB] random traffic");
    for (int n = 0; n < 1000; n++) begin
      bit va, vb;
      va = 1'($urandom_range(0, 1));
      vb = 1'($urandom_range(0, 1));
      if (!va && !vb) va = 1;
      applyStimulus(va, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                    vb, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end

    $display("[TB] READ_WAIT=3 instance");
    runLongRead(1, 3'd7, 8'h5A);
    runLongRead(0, 3'd7, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
